// File: rtl/mips_divider.sv
// mips_divider
// -----------------------------------------------------------------------------
// Multi-cycle restoring divider for the MIPS DIV / DIVU instructions.
// It produces one quotient bit per clock, so the latency is fixed.
// The quotient feeds LO and the remainder feeds HI.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; forces IDLE and clears all outputs
//   start        request a division (sampled only while idle)
//   is_signed    1 = DIV (two's complement), 0 = DIVU; captured with start
//   dividend     numerator; captured with start
//   divisor      denominator; captured with start
//   busy         high from the edge after acceptance until done
//   done         one-cycle pulse; results are valid from this cycle onward
//   quotient     result to LO (held until the next operation finishes)
//   remainder    result to HI (held until the next operation finishes)
//   div_by_zero  set with done when the captured divisor was zero
//
// Latency: if start is sampled at edge N, RUN occupies edges N+1..N+WIDTH,
// FIX is edge N+WIDTH+1, and done is high for the cycle after that edge.
// -----------------------------------------------------------------------------
module mips_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic             q_neg_reg;   // negate the quotient at FIX
  logic             r_neg_reg;   // negate the remainder at FIX
  logic             zero_reg;    // captured divisor was zero
  logic [WIDTH-1:0] orig_reg;    // unmodified dividend, returned on divide by zero
  logic [WIDTH-1:0] dvs_reg;     // divisor magnitude
  logic [WIDTH-1:0] rem_reg;     // partial remainder
  logic [WIDTH-1:0] quo_reg;     // dividend magnitude shifting out, quotient shifting in

  // Operand signs only count in signed mode.
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];

  // The most negative value negates to itself. Read as unsigned, that is
  // exactly its magnitude, so no special case is needed.
  assign dvd_mag = dvd_neg ? (~dividend + ONE) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + ONE) : divisor;

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value fits in WIDTH+1 bits. The top bit of the difference
  // is therefore a reliable borrow flag.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_reg, quo_reg[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_reg};

  // Sign correction applied at FIX.
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign q_fix = q_neg_reg ? (~quo_reg + ONE) : quo_reg;
  assign r_fix = r_neg_reg ? (~rem_reg + ONE) : rem_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      zero_reg    <= 1'b0;
      orig_reg    <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            orig_reg  <= dividend;
            zero_reg  <= (divisor == '0);
            q_neg_reg <= dvd_neg ^ dvs_neg;
            r_neg_reg <= dvd_neg;
            quo_reg   <= dvd_mag;
            dvs_reg   <= dvs_mag;
            rem_reg   <= '0;
            count_reg <= CW'(WIDTH);
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end

        RUN: begin
          if (diff[WIDTH]) begin
            rem_reg <= shifted[WIDTH-1:0];  // borrow: restore
          end else begin
            rem_reg <= diff[WIDTH-1:0];
          end
          quo_reg   <= {quo_reg[WIDTH-2:0], ~diff[WIDTH]};
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= FIX;
          end
        end

        FIX: begin
          // With a zero divisor every trial subtract succeeds. That leaves
          // all ones in the quotient, but the remainder path is meaningless,
          // so the captured dividend is returned unmodified instead.
          if (zero_reg) begin
            quotient  <= '1;
            remainder <= orig_reg;
          end else begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
          div_by_zero <= zero_reg;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_reg   <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_divider.sv
// Bench for mips_divider (WIDTH=32).
// Expected results are queued when an operation is started. A monitor pops
// and compares them on each done pulse. The stimulus tasks check the
// handshake timing.
module tb_mips_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  mips_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, required no pending operation");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
        $display("op done: q=0x%08h r=0x%08h dz=%0b (expect q=0x%08h r=0x%08h dz=%0b)",
                 quotient, remainder, div_by_zero, e.q, e.r, e.z);
      end
    end
  end

  // Start an operation (sampled at the next posedge) and queue its result.
  // Returns at the negedge just after the acceptance edge.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input logic z);
    exp_t e;
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    e.q = q; e.r = r; e.z = z;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Wait for done, counting negedges. Busy must stay high while waiting.
  task automatic wait_done(output int lat);
    bit busy_ok;
    busy_ok = 1'b1;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in 60 cycles, required done");
    end
    check("busy_while_running", {31'd0, busy_ok}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[$];
  vec_t v;
  int   lat;
  int   done_seen;
  logic signed [31:0] sa;
  logic signed [31:0] sbv;

  initial begin
    vecs.push_back('{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0});
    vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0});
    vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0});
    vecs.push_back('{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0});
    vecs.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0});
    vecs.push_back('{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0});
    vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0});
    vecs.push_back('{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1});
    vecs.push_back('{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1});
    vecs.push_back('{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0});
    vecs.push_back('{1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0});
    vecs.push_back('{1'b1, 32'hFFFFFFFF,   32'h80000000,   32'd0,          32'hFFFFFFFF,   1'b0});

    // A few random operands, checked against the simulator's own arithmetic.
    for (int i = 0; i < 6; i++) begin
      v.sgn = i[0];
      v.a = $urandom;
      v.b = $urandom >> $urandom_range(0, 28);
      if (v.b == 32'd0) v.b = 32'd3;
      if (v.sgn && v.a == 32'h80000000 && v.b == 32'hFFFFFFFF) v.b = 32'd5;
      if (v.sgn) begin
        sa = v.a; sbv = v.b;
        v.q = sa / sbv;
        v.r = sa % sbv;
      end else begin
        v.q = v.a / v.b;
        v.r = v.a % v.b;
      end
      v.z = 1'b0;
      vecs.push_back(v);
    end

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_dz", {31'd0, div_by_zero}, 32'd0);

    // Table: each operation must finish 33 edges after acceptance.
    foreach (vecs[k]) begin
      start_op(vecs[k].sgn, vecs[k].a, vecs[k].b, vecs[k].q, vecs[k].r, vecs[k].z);
      wait_done(lat);
      check("latency", lat, 32'd33);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
    end

    // A start raised at edge N+10 during an operation must be ignored.
    start_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (9) @(negedge clk);
    start = 1'b1; is_signed = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("latency_ignored_start", lat, 32'd23);
    @(negedge clk);
    check("no_second_op", {31'd0, busy}, 32'd0);

    // A start raised during the done cycle is accepted; the next done follows 34 edges later.
    start_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_done(lat);
    start_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    wait_done(lat);
    check("latency_back_to_back", lat + 1, 32'd34);
    @(negedge clk);

    // A reset sampled at edge N+15 aborts the operation with no done pulse.
    start_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_dz", {31'd0, div_by_zero}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("abort_no_done", done_seen, 32'd0);

    start_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_done(lat);
    check("latency_after_reset", lat, 32'd33);
    @(negedge clk);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_divider.md
# mips_divider

Multi-cycle iterative restoring divider for the MIPS datapath, implementing DIV and DIVU. It is the inverse counterpart of the adder/multiplier arithmetic and feeds the HI/LO registers: the quotient goes to LO and the remainder to HI. The core handles one operation at a time through a start/busy/done handshake and produces one quotient bit per clock, so latency is fixed.

## Interface

Parameters:

- `WIDTH`, default 32: operand and result width in bits; must be at least 2.

Ports:

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high; forces IDLE and clears all outputs.
- `start`, input, 1: request a division. Sampled only in IDLE.
- `is_signed`, input, 1: 1 = DIV (two's complement), 0 = DIVU. Captured with `start`.
- `dividend`, input, WIDTH: numerator. Captured with `start`.
- `divisor`, input, WIDTH: denominator. Captured with `start`.
- `busy`, output, 1: high from the edge after acceptance until `done` asserts.
- `done`, output, 1: one-cycle pulse; results are valid from this cycle onward.
- `quotient`, output, WIDTH: to LO.
- `remainder`, output, WIDTH: to HI.
- `div_by_zero`, output, 1: set with `done` when the captured divisor is 0.

## Operation

- States: IDLE, RUN, FIX.
- **IDLE**
  - On `start`=1, capture `is_signed` and both operands.
  - Latch the sign flags: quotient sign = dividend sign XOR divisor sign; remainder sign = dividend sign. Both flags apply only when `is_signed`.
  - Load the operand magnitudes (absolute value when signed) into the working registers, clear the partial remainder, set the bit counter to WIDTH, then go to RUN.
- **RUN**, one iteration per cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude using a WIDTH+1 bit subtraction.
  - If the result is non-negative, keep it and shift in quotient bit 1. Otherwise restore and shift in 0.
  - Decrement the counter. After WIDTH iterations, go to FIX.
- **FIX**
  - Apply the signs: negate the quotient if its sign flag is set; negate the remainder if its sign flag is set.
  - Drive `quotient`, `remainder` and `div_by_zero`, pulse `done`, then return to IDLE.
- Arithmetic rules:
  - Signed results truncate toward zero. The remainder takes the sign of the dividend.
  - The most negative value is handled by the magnitude path: the unsigned magnitude of 0x80000000 is 0x80000000.
  - Signed overflow, (−2^(WIDTH−1)) / (−1): quotient = 0x80000000, remainder = 0, no flag.
- Divide by zero, either mode:
  - Quotient = all ones, remainder = the original captured dividend (unmodified), `div_by_zero`=1.
  - Same latency as a normal divide; there is no early exit.
- `start` while `busy` is ignored; the in-flight operation is not disturbed.
- `start` in the same cycle that `done` is high is accepted, because the FSM is already in IDLE.
- Outputs hold their last values until the FIX edge of the next operation. `div_by_zero` updates only at FIX.

## Timing

- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, state IDLE, counter 0.
- Reset mid-operation aborts at the next edge: IDLE with all outputs at their reset values, and no `done` pulse.
- Latency, with `start` sampled at edge N:
  - `busy`=1 after edge N.
  - RUN occupies edges N+1 … N+WIDTH.
  - FIX is edge N+WIDTH+1. After that edge, `done`=1 and `busy`=0 for exactly one cycle, with results valid.
  - For WIDTH=32, `done` is set by edge N+33.
- Throughput is one operation per WIDTH+2 cycles.
- There is no combinational path from inputs to outputs.

## Test plan

- **Unsigned, basic.** DIVU 100 / 7, `start` at edge N -> `quotient`=14, `remainder`=2, `div_by_zero`=0, `done` high for exactly one cycle after edge N+33, `busy` high after edges N … N+32.
- **Signed, mixed signs.** DIV 0xFFFFFFF9 (−7) / 2 -> `quotient`=0xFFFFFFFD (−3), `remainder`=0xFFFFFFFF (−1). Also −7 / −2 -> 3 and 0xFFFFFFFF; 7 / −2 -> 0xFFFFFFFD and 1.
- **Most-negative operand.**
  - DIV 0x80000000 / 0xFFFFFFFF -> `quotient`=0x80000000, `remainder`=0.
  - DIVU on the same operands -> `quotient`=0, `remainder`=0x80000000.
  - DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF, 0.
- **Divide by zero.** DIVU 5 / 0 and DIV 0xFFFFFFFB / 0 -> `quotient`=0xFFFFFFFF, `remainder`=the original dividend, `div_by_zero`=1. `done` arrives at the same edge as a normal divide. A following DIVU 9 / 3 -> 3, 0, with `div_by_zero`=0.
- **Handshake boundaries.**
  - `start` with different operands at edge N+10 during 100 / 7 -> ignored; the result is still 14, 2.
  - `start` in the `done` cycle -> accepted; the next `done` arrives 34 edges later.
- **Reset mid-operation.** `reset` at edge N+15 -> `busy`=0, `quotient`=`remainder`=0, `div_by_zero`=0, and no `done` pulse. A subsequent 100 / 7 completes normally.
